decode_stage: RTL and testbench
===============================

# decode_stage

Single-issue instruction decode stage that drives the core ALU's control interface. Accepts one 32-bit RV32I instruction word plus PC per valid/ready handshake and emits a registered control bundle: ALU opcode (`ALU_*` constants from `core.svh`), signedness flag, operand selects, immediate, register indices and memory/branch strobes. It sits between fetch and execute; execute feeds `alu_op`/`unsigned_flag` straight into the ALU.

## Interface
- Parameters:
- `RESET_PC`, 32'h0000_0000, value driven on `out_pc` during reset.
- Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `reset_n`  in  1  synchronous active-low reset.
- `flush`  in  1  synchronous kill of all held instructions (branch redirect).
- `in_valid`  in  1  fetch offers `in_instr`/`in_pc`.
- `in_ready`  out  1  stage accepts this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  its address.
- `out_valid`  out  1  bundle valid.
- `out_ready`  in  1  execute consumes bundle.
- `out_pc`  out  32  PC of bundle.
- `alu_op`  out  4  `ALU_AND/OR/ADD/SUB/EQ/NE/LT/GE`.
- `unsigned_flag`  out  1  unsigned compare (SLTU/SLTIU/BLTU/BGEU).
- `a_sel`  out  2  0=rs1, 1=pc, 2=zero.
- `b_sel`  out  1  0=rs2, 1=imm.
- `imm`  out  32  sign-extended immediate (I/S/B/U/J per format).
- `rs1`, `rs2`, `rd`  out  5 each  register indices.
- `reg_we`, `mem_re`, `mem_we`, `branch`, `jump`  out  1 each  strobes.
- `illegal`  out  1  unsupported encoding.

## Operation
- Decode map (opcode/funct3/funct7): ADD/ADDI/LW/SW/JAL/JALR→ALU_ADD; SUB→ALU_SUB; AND/ANDI→ALU_AND; OR/ORI→ALU_OR; SLT/SLTI/BLT→ALU_LT; SLTU/SLTIU/BLTU→ALU_LT+unsigned; BGE/BGEU→ALU_GE (+unsigned); BEQ→ALU_EQ; BNE→ALU_NE.
- LUI: a_sel=2, b_sel=1, ALU_ADD. AUIPC: a_sel=1, b_sel=1. JAL: a_sel=1, jump=1, reg_we=1. Loads/stores: b_sel=1, address via ALU_ADD.
- XOR, shifts, FENCE, SYSTEM, any other opcode or funct7 not 0x00 (0x20 only for SUB): illegal=1, reg_we=mem_re=mem_we=branch=jump=0, alu_op=ALU_ADD.
- Writes to rd=0: reg_we forced 0.
- Output register loads when `in_valid && in_ready`; holds all fields while `out_valid && !out_ready`.
- `out_valid` clears on `out_ready` with no new accept.
- Reset (`!reset_n`): out_valid=0, skid empty, all strobes/illegal=0, alu_op=ALU_ADD, a_sel=0, b_sel=0, imm/rs*/rd=0, out_pc=RESET_PC. Reset overrides flush and handshake; in-flight instruction lost.
- Flush: next cycle out_valid=0 and skid empty; instruction offered during flush cycle is dropped (in_ready may be 1; it is not loaded).

## Timing
- Latency: instruction accepted in cycle N is on outputs with out_valid=1 in N+1.
- Throughput one per cycle with out_ready held 1.
- in_valid must stay high with stable data until accepted; out side holds identically.
- Without skid: `in_ready = !out_valid || out_ready` (combinational from out_ready).
- Simultaneous accept and consume: new bundle replaces old, out_valid stays 1.

## Configuration
- `DECODE_SKID_EN` defined: one-entry skid buffer; `in_ready` is a register (`!skid_valid`), no combinational path out_ready→in_ready. Accept while output stalled writes skid; skid drains into output register when out_ready. Order preserved; flush/reset empty both.
- Undefined: no skid; in_ready combinational as above. Cycle-level output sequence identical for all handshake patterns where in_valid is not stalled.

## Test plan
- `0x002081B3` (add x3,x1,x2) → next cycle alu_op=ALU_ADD, rs1=1, rs2=2, rd=3, b_sel=0, reg_we=1, illegal=0.
- `0xFFF00293` (addi x5,x0,-1) → imm=0xFFFFFFFF, b_sel=1, rd=5, reg_we=1.
- `0x0020E463` (bltu x1,x2,+8) → alu_op=ALU_LT, unsigned_flag=1, branch=1, imm=0x00000008, reg_we=0.
- `0x003140B3` (xor) → illegal=1, all strobes 0.
- out_ready=0 for 3 cycles with 3 back-to-back instrs → first held stable, none lost/duplicated, in-order drain; flush mid-stall → out_valid=0 next cycle.
- reset_n low while out_valid=1 → next cycle out_valid=0, out_pc=RESET_PC, alu_op=ALU_ADD.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: one instruction per valid/ready handshake, registered ALU control bundle.
// Define DECODE_SKID_EN to add a one-entry skid buffer that registers in_ready.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  alu_op,
    output logic        unsigned_flag,
    output logic [1:0]  a_sel,
    output logic        b_sel,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        branch,
    output logic        jump,
    output logic        illegal
);

    // ALU opcode encodings shared with execute (core.svh).
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_EQ  = 4'd4;
    localparam logic [3:0] ALU_NE  = 4'd5;
    localparam logic [3:0] ALU_LT  = 4'd6;
    localparam logic [3:0] ALU_GE  = 4'd7;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic        uns;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jump;
        logic        illegal;
    } bundle_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        writes_rd;
    logic        bad;
    logic        accept;
    bundle_t     dec;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'h000};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.alu_op = ALU_ADD;
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.rd     = in_instr[11:7];
        writes_rd  = 1'b0;
        bad        = 1'b0;

        case (opcode)
            OP_REG: begin
                writes_rd = 1'b1;
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'b000:  dec.alu_op = ALU_ADD;
                        3'b111:  dec.alu_op = ALU_AND;
                        3'b110:  dec.alu_op = ALU_OR;
                        3'b010:  dec.alu_op = ALU_LT;
                        3'b011: begin
                            dec.alu_op = ALU_LT;
                            dec.uns    = 1'b1;
                        end
                        default: bad = 1'b1;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    dec.alu_op = ALU_SUB;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_IMM: begin
                writes_rd = 1'b1;
                dec.b_sel = 1'b1;
                dec.imm   = imm_i;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_ADD;
                    3'b111:  dec.alu_op = ALU_AND;
                    3'b110:  dec.alu_op = ALU_OR;
                    3'b010:  dec.alu_op = ALU_LT;
                    3'b011: begin
                        dec.alu_op = ALU_LT;
                        dec.uns    = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                writes_rd  = 1'b1;
                dec.mem_re = 1'b1;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_i;
                bad        = (funct3 != 3'b010);
            end
            OP_STORE: begin
                dec.mem_we = 1'b1;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_s;
                bad        = (funct3 != 3'b010);
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = imm_b;
                dec.uns    = funct3[1];
                case (funct3)
                    3'b000:         dec.alu_op = ALU_EQ;
                    3'b001:         dec.alu_op = ALU_NE;
                    3'b100, 3'b110: dec.alu_op = ALU_LT;
                    3'b101, 3'b111: dec.alu_op = ALU_GE;
                    default:        bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                writes_rd = 1'b1;
                dec.jump  = 1'b1;
                dec.a_sel = 2'd1;
                dec.b_sel = 1'b1;
                dec.imm   = imm_j;
            end
            OP_JALR: begin
                writes_rd = 1'b1;
                dec.jump  = 1'b1;
                dec.b_sel = 1'b1;
                dec.imm   = imm_i;
                bad       = (funct3 != 3'b000);
            end
            OP_LUI: begin
                writes_rd = 1'b1;
                dec.a_sel = 2'd2;
                dec.b_sel = 1'b1;
                dec.imm   = imm_u;
            end
            OP_AUIPC: begin
                writes_rd = 1'b1;
                dec.a_sel = 2'd1;
                dec.b_sel = 1'b1;
                dec.imm   = imm_u;
            end
            default: bad = 1'b1;
        endcase

        // Unsupported encodings collapse to a harmless ADD with every side effect suppressed.
        if (bad) begin
            dec.alu_op = ALU_ADD;
            dec.uns    = 1'b0;
            dec.a_sel  = 2'd0;
            dec.b_sel  = 1'b0;
            dec.imm    = '0;
            dec.mem_re = 1'b0;
            dec.mem_we = 1'b0;
            dec.branch = 1'b0;
            dec.jump   = 1'b0;
            writes_rd  = 1'b0;
        end
        dec.illegal = bad;
        dec.reg_we  = writes_rd && (dec.rd != 5'd0);
    end

    bundle_t out_q, out_d;
    logic    out_valid_q, out_valid_d;

    assign accept = in_valid && in_ready && !flush;

`ifdef DECODE_SKID_EN
    bundle_t skid_q, skid_d;
    logic    skid_valid_q, skid_valid_d;

    assign in_ready = !skid_valid_q;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Skid full implies in_ready is low, so no new accept competes with the drain.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q        <= '0;
            out_q.pc     <= RESET_PC;
            out_q.alu_op <= ALU_ADD;
            out_valid_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_q.pc;
    assign alu_op        = out_q.alu_op;
    assign unsigned_flag = out_q.uns;
    assign a_sel         = out_q.a_sel;
    assign b_sel         = out_q.b_sel;
    assign imm           = out_q.imm;
    assign rs1           = out_q.rs1;
    assign rs2           = out_q.rs2;
    assign rd            = out_q.rd;
    assign reg_we        = out_q.reg_we;
    assign mem_re        = out_q.mem_re;
    assign mem_we        = out_q.mem_we;
    assign branch        = out_q.branch;
    assign jump          = out_q.jump;
    assign illegal       = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: instructions are built from mnemonics, and the expected
// bundle comes from the mnemonic's meaning; a monitor compares every presented bundle.
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_EQ  = 4'd4;
    localparam logic [3:0] ALU_NE  = 4'd5;
    localparam logic [3:0] ALU_LT  = 4'd6;
    localparam logic [3:0] ALU_GE  = 4'd7;

    localparam int F_R = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5;

    typedef enum int {
        K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SLTU,
        K_ADDI, K_ANDI, K_ORI, K_SLTI, K_SLTIU, K_LW, K_SW,
        K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
        K_JAL, K_JALR, K_LUI, K_AUIPC,
        K_XOR, K_SLL, K_SRA, K_BADF7, K_XORI, K_SLLI, K_FENCE, K_ECALL,
        K_LB, K_SB, K_BADBR, K_BADJALR, K_BADOP,
        K_COUNT
    } kind_e;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  alu;
        logic        uns;
        logic [1:0]  a;
        logic        b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        re;
        logic        wr;
        logic        br;
        logic        jp;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [3:0]  alu_op;
    logic        unsigned_flag, b_sel, reg_we, mem_re, mem_we, branch, jump, illegal;
    logic [1:0]  a_sel;
    logic [4:0]  rs1, rs2, rd;

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_op(alu_op), .unsigned_flag(unsigned_flag), .a_sel(a_sel), .b_sel(b_sel),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .branch(branch), .jump(jump),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int   nvec = 0;
    int   nfail = 0;
    exp_t sb[$];
    exp_t cur_exp;
    bit   offer_done = 1'b0;
    bit   offer_acc = 1'b0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] alu, input logic uns,
                                input logic [1:0] a, input logic b, input logic [31:0] iv,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                input logic we, input logic re, input logic wr, input logic br,
                                input logic jp, input logic ill);
        exp_t e;
        e.pc = pc; e.alu = alu; e.uns = uns; e.a = a; e.b = b; e.imm = iv;
        e.rs1 = r1; e.rs2 = r2; e.rd = d;
        e.we = we; e.re = re; e.wr = wr; e.br = br; e.jp = jp; e.ill = ill;
        return e;
    endfunction

    // Encode a mnemonic with random operands; the expectation follows from what it means.
    task automatic gen(input kind_e k, input logic [31:0] pc, output logic [31:0] w,
                       output exp_t e);
        logic [4:0]  r1, r2, d;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] iv, t;
        logic [3:0]  alu;
        logic [1:0]  a;
        logic        uns, b, we, re, wr, br, jp, ill;
        int          fmt;
        r1 = 5'($urandom); r2 = 5'($urandom);
        d  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        t  = $urandom;
        op = 7'b0110011; f3 = 3'd0; f7 = 7'd0; fmt = F_R;
        alu = ALU_ADD; uns = 0; a = 2'd0; b = 0; we = 0; re = 0; wr = 0; br = 0; jp = 0; ill = 0;
        case (k)
            K_ADD:    we = 1;
            K_SUB:    begin f7 = 7'h20; alu = ALU_SUB; we = 1; end
            K_AND:    begin f3 = 3'd7; alu = ALU_AND; we = 1; end
            K_OR:     begin f3 = 3'd6; alu = ALU_OR; we = 1; end
            K_SLT:    begin f3 = 3'd2; alu = ALU_LT; we = 1; end
            K_SLTU:   begin f3 = 3'd3; alu = ALU_LT; uns = 1; we = 1; end
            K_ADDI:   begin op = 7'b0010011; fmt = F_I; b = 1; we = 1; end
            K_ANDI:   begin op = 7'b0010011; fmt = F_I; f3 = 3'd7; alu = ALU_AND; b = 1; we = 1; end
            K_ORI:    begin op = 7'b0010011; fmt = F_I; f3 = 3'd6; alu = ALU_OR; b = 1; we = 1; end
            K_SLTI:   begin op = 7'b0010011; fmt = F_I; f3 = 3'd2; alu = ALU_LT; b = 1; we = 1; end
            K_SLTIU:  begin
                op = 7'b0010011; fmt = F_I; f3 = 3'd3; alu = ALU_LT; uns = 1; b = 1; we = 1;
            end
            K_LW:     begin op = 7'b0000011; fmt = F_I; f3 = 3'd2; b = 1; re = 1; we = 1; end
            K_SW:     begin op = 7'b0100011; fmt = F_S; f3 = 3'd2; b = 1; wr = 1; end
            K_BEQ:    begin op = 7'b1100011; fmt = F_B; f3 = 3'd0; alu = ALU_EQ; br = 1; end
            K_BNE:    begin op = 7'b1100011; fmt = F_B; f3 = 3'd1; alu = ALU_NE; br = 1; end
            K_BLT:    begin op = 7'b1100011; fmt = F_B; f3 = 3'd4; alu = ALU_LT; br = 1; end
            K_BGE:    begin op = 7'b1100011; fmt = F_B; f3 = 3'd5; alu = ALU_GE; br = 1; end
            K_BLTU:   begin op = 7'b1100011; fmt = F_B; f3 = 3'd6; alu = ALU_LT; uns = 1; br = 1; end
            K_BGEU:   begin op = 7'b1100011; fmt = F_B; f3 = 3'd7; alu = ALU_GE; uns = 1; br = 1; end
            K_JAL:    begin op = 7'b1101111; fmt = F_J; a = 2'd1; b = 1; jp = 1; we = 1; end
            K_JALR:   begin op = 7'b1100111; fmt = F_I; b = 1; jp = 1; we = 1; end
            K_LUI:    begin op = 7'b0110111; fmt = F_U; a = 2'd2; b = 1; we = 1; end
            K_AUIPC:  begin op = 7'b0010111; fmt = F_U; a = 2'd1; b = 1; we = 1; end
            K_XOR:    begin f3 = 3'd4; ill = 1; end
            K_SLL:    begin f3 = 3'd1; ill = 1; end
            K_SRA:    begin f3 = 3'd5; f7 = 7'h20; ill = 1; end
            K_BADF7:  begin f7 = 7'h01; ill = 1; end
            K_XORI:   begin op = 7'b0010011; fmt = F_I; f3 = 3'd4; ill = 1; end
            K_SLLI:   begin op = 7'b0010011; fmt = F_I; f3 = 3'd1; ill = 1; end
            K_FENCE:  begin op = 7'b0001111; fmt = F_I; ill = 1; end
            K_ECALL:  begin op = 7'b1110011; fmt = F_I; ill = 1; end
            K_LB:     begin op = 7'b0000011; fmt = F_I; f3 = 3'd0; ill = 1; end
            K_SB:     begin op = 7'b0100011; fmt = F_S; f3 = 3'd0; ill = 1; end
            K_BADBR:  begin op = 7'b1100011; fmt = F_B; f3 = 3'd2; ill = 1; end
            K_BADJALR: begin op = 7'b1100111; fmt = F_I; f3 = 3'd1; ill = 1; end
            default:  begin op = 7'b1011011; f3 = 3'(t); ill = 1; end
        endcase
        case (fmt)
            F_I, F_S: iv = {{20{t[11]}}, t[11:0]};
            F_B:      iv = {{19{t[12]}}, t[12:1], 1'b0};
            F_U:      iv = {t[31:12], 12'h000};
            F_J:      iv = {{11{t[20]}}, t[20:1], 1'b0};
            default:  iv = 32'd0;
        endcase
        case (fmt)
            F_I:     w = {iv[11:0], r1, f3, d, op};
            F_S:     w = {iv[11:5], r2, r1, f3, iv[4:0], op};
            F_B:     w = {iv[12], iv[10:5], r2, r1, f3, iv[4:1], iv[11], op};
            F_U:     w = {iv[31:12], d, op};
            F_J:     w = {iv[20], iv[10:1], iv[11], iv[19:12], d, op};
            default: w = {f7, r2, r1, f3, d, op};
        endcase
        e = mk(pc, alu, uns, a, b, ill ? 32'd0 : iv, w[19:15], w[24:20], w[11:7],
               we && (w[11:7] != 5'd0), re, wr, br, jp, ill);
    endtask

    // Stimulus-side bookkeeping, sampled just after the monitor at the falling edge.
    always @(negedge clk) begin
        #1;
        offer_acc  = (reset_n === 1'b1) && !flush && in_valid && (in_ready === 1'b1);
        offer_done = (reset_n !== 1'b1) || flush || offer_acc;
        if (reset_n !== 1'b1 || flush) sb.delete();
        else if (offer_acc) sb.push_back(cur_exp);
    end

    // Monitor: every presented bundle must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n === 1'b1) begin
`ifndef DECODE_SKID_EN
            cmp("in_ready_comb", 32'(in_ready), 32'(!out_valid || out_ready));
`endif
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_bundle @%0t: got out_pc %h, expected none",
                             $time, out_pc);
                end else begin
                    e = sb[0];
                    cmp("out_pc", out_pc, e.pc);
                    cmp("alu_op", 32'(alu_op), 32'(e.alu));
                    cmp("unsigned_flag", 32'(unsigned_flag), 32'(e.uns));
                    cmp("a_sel", 32'(a_sel), 32'(e.a));
                    cmp("b_sel", 32'(b_sel), 32'(e.b));
                    cmp("imm", imm, e.imm);
                    cmp("rs1", 32'(rs1), 32'(e.rs1));
                    cmp("rs2", 32'(rs2), 32'(e.rs2));
                    cmp("rd", 32'(rd), 32'(e.rd));
                    cmp("reg_we", 32'(reg_we), 32'(e.we));
                    cmp("mem_re", 32'(mem_re), 32'(e.re));
                    cmp("mem_we", 32'(mem_we), 32'(e.wr));
                    cmp("branch", 32'(branch), 32'(e.br));
                    cmp("jump", 32'(jump), 32'(e.jp));
                    cmp("illegal", 32'(illegal), 32'(e.ill));
                    if (out_ready === 1'b1) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] pc, input exp_t e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        cur_exp  = e;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (offer_done) begin
                done = 1'b1;
                if (offer_acc) cmp("accept_latency", 32'(out_valid), 32'd1);
            end
        end
        if (!done) begin
            nvec++;
            nfail++;
            $display("FAIL offer_timeout @%0t: got no accept, expected one within 40 cycles",
                     $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        cmp({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        cmp({tag, ".out_pc"}, out_pc, RST_PC);
        cmp({tag, ".alu_op"}, 32'(alu_op), 32'(ALU_ADD));
        cmp({tag, ".imm"}, imm, 32'd0);
        cmp({tag, ".sel"}, 32'({a_sel, b_sel}), 32'd0);
        cmp({tag, ".strobes"}, 32'({reg_we, mem_re, mem_we, branch, jump, illegal}), 32'd0);
        cmp({tag, ".regs"}, 32'({rs1, rs2, rd}), 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected end within 1000000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w, wb, pc;
        exp_t        e, eb;
        bit          pending;
        kind_e       k;

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; in_pc = 32'd0; cur_exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check_reset_state("reset");
        reset_n = 1'b1;
        step();
        cmp("idle_in_ready", 32'(in_ready), 32'd1);

        // Reference words from the test plan with hand-derived bundles.
        offer(32'h002081B3, 32'h100,
              mk(32'h100, ALU_ADD, 0, 0, 0, 32'h0, 1, 2, 3, 1, 0, 0, 0, 0, 0));
        offer(32'hFFF00293, 32'h104,
              mk(32'h104, ALU_ADD, 0, 0, 1, 32'hFFFF_FFFF, 0, 31, 5, 1, 0, 0, 0, 0, 0));
        offer(32'h0020E463, 32'h108,
              mk(32'h108, ALU_LT, 1, 0, 0, 32'h8, 1, 2, 8, 0, 0, 0, 1, 0, 0));
        offer(32'h003140B3, 32'h10C,
              mk(32'h10C, ALU_ADD, 0, 0, 0, 32'h0, 2, 3, 1, 0, 0, 0, 0, 0, 1));
        offer(32'h00000033, 32'h110,
              mk(32'h110, ALU_ADD, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        in_valid = 1'b0;
        repeat (2) step();

        // Three back-to-back instructions against a three-cycle stall.
        out_ready = 1'b0;
        fork
            begin
                gen(K_LW, 32'h200, w, e);   offer(w, 32'h200, e);
                gen(K_SUB, 32'h204, w, e);  offer(w, 32'h204, e);
                gen(K_BGEU, 32'h208, w, e); offer(w, 32'h208, e);
                in_valid = 1'b0;
            end
            begin
                repeat (4) step();
                out_ready = 1'b1;
            end
        join
        repeat (3) step();
        cmp("stall_drained", 32'(sb.size()), 32'd0);

        // Flush while stalled with a second instruction waiting.
        out_ready = 1'b0;
        gen(K_LUI, 32'h300, w, e);
        in_valid = 1'b1; in_instr = w; in_pc = 32'h300; cur_exp = e;
        step();
        gen(K_AUIPC, 32'h304, wb, eb);
        in_instr = wb; in_pc = 32'h304; cur_exp = eb;
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        cmp("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (2) step();
        cmp("flush_nothing_left", 32'(out_valid), 32'd0);

        // Reset with a valid bundle held.
        out_ready = 1'b0;
        offer(32'h0020E463, 32'h400,
              mk(32'h400, ALU_LT, 1, 0, 0, 32'h8, 1, 2, 8, 0, 0, 0, 1, 0, 0));
        in_valid = 1'b0;
        reset_n = 1'b0;
        step();
        check_reset_state("reset_inflight");
        reset_n = 1'b1; out_ready = 1'b1;
        step();

        // Randomised traffic with stalls, occasional flushes and resets.
        pending = 1'b0;
        pc = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                k = kind_e'($urandom_range(0, int'(K_COUNT) - 1));
                gen(k, pc, w, e);
                in_instr = w; in_pc = pc; cur_exp = e;
                pc = pc + 32'(4 * $urandom_range(1, 3));
                pending = 1'b1;
            end
            in_valid  = pending;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            reset_n   = ($urandom_range(0, 399) != 0);
            step();
            if (offer_done) pending = 1'b0;
        end

        reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        cmp("final_drained", 32'(sb.size()), 32'd0);
        cmp("final_out_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
